// File: rtl/xrv_imem_if.sv
// Fetch and loader signal bundle for the instruction memory.
// The master side is the fetcher/boot streamer; the slave side is xrv_imem.
interface xrv_imem_if #(
    parameter int DEPTH = 4096
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_busy;
    logic        ld_overflow;
    logic [AW:0] ld_words;
    logic        core_hold;

    modport master (
        output i_addr, ld_start, ld_valid, ld_byte, ld_last,
        input  i_data, ld_busy, ld_overflow, ld_words, core_hold
    );

    modport slave (
        input  i_addr, ld_start, ld_valid, ld_byte, ld_last,
        output i_data, ld_busy, ld_overflow, ld_words, core_hold
    );
endinterface

// File: rtl/xrv_imem.sv
// Instruction memory: one-cycle word reads for the fetcher, plus a byte-serial
// little-endian program loader that holds the core while it fills the array.
module xrv_imem #(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       rstb,
    xrv_imem_if.slave  bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [1:0]    lane_q, lane_d;
    logic [23:0]   asm_q, asm_d;
    logic [AW:0]   words_q, words_d;
    logic          ovf_q, ovf_d;
    logic          we;
    logic [31:0]   wdata;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   offset;
    logic [AW-1:0] ridx;
    logic          in_range;

    assign offset   = bus.i_addr - BASE_ADDR;
    assign ridx     = offset[AW+1:2];
    assign in_range = offset < SPAN;

    // Registered read of the pre-edge array contents gives read-first ordering
    // against a same-cycle loader write.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) bus.i_data <= NOP_WORD;
        else       bus.i_data <= in_range ? mem[ridx] : NOP_WORD;
    end

    // NOTE: the array has no reset so it maps onto RAM macros; only control state is reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr_q] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            waddr_q <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            words_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            words_q <= words_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        words_d = words_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        wdata   = '0;

        case (state_q)
            IDLE: begin
                if (bus.ld_start) begin
                    state_d = LOAD;
                    waddr_d = '0;
                    lane_d  = '0;
                    asm_d   = '0;
                    words_d = '0;
                    ovf_d   = 1'b0;
                end
            end

            LOAD: begin
                if (bus.ld_start) begin
                    // Restart drops the partial word and any coincident byte.
                    waddr_d = '0;
                    lane_d  = '0;
                    asm_d   = '0;
                    words_d = '0;
                    ovf_d   = 1'b0;
                end else if (bus.ld_valid) begin
                    if (lane_q == 2'd3) begin
                        we      = 1'b1;
                        wdata   = {bus.ld_byte, asm_q};
                        waddr_d = waddr_q + AW'(1);
                        words_d = words_q + (AW+1)'(1);
                        lane_d  = '0;
                        asm_d   = '0;
                        if (waddr_q == AW'(DEPTH - 1)) ovf_d = 1'b1;
                        if (bus.ld_last) state_d = IDLE;
                    end else begin
                        case (lane_q)
                            2'd0:    asm_d[7:0]   = bus.ld_byte;
                            2'd1:    asm_d[15:8]  = bus.ld_byte;
                            default: asm_d[23:16] = bus.ld_byte;
                        endcase
                        lane_d = lane_q + 2'd1;
                        if (bus.ld_last) state_d = FLUSH;
                    end
                end
            end

            FLUSH: begin
                we      = 1'b1;
                wdata   = {8'h00, asm_q};
                waddr_d = waddr_q + AW'(1);
                words_d = words_q + (AW+1)'(1);
                lane_d  = '0;
                asm_d   = '0;
                state_d = IDLE;
                if (bus.ld_start) begin
                    state_d = LOAD;
                    waddr_d = '0;
                    words_d = '0;
                    ovf_d   = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Decoded straight from the state flop so reset releases the core asynchronously.
    assign bus.core_hold   = (state_q != IDLE);
    assign bus.ld_busy     = (state_q != IDLE);
    assign bus.ld_overflow = ovf_q;
    assign bus.ld_words    = words_q;
endmodule

// File: tb/tb_xrv_imem.sv
// Self-checking bench for xrv_imem: read-vector tables through a scoreboard
// queue, plus hand-written loader sequences for the multi-cycle corner cases.
module tb_xrv_imem;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    xrv_imem_if #(.DEPTH(DEPTH)) bus ();

    xrv_imem #(
        .DEPTH    (DEPTH),
        .BASE_ADDR(32'h0000_0000),
        .NOP_WORD (32'h0000_0013)
    ) u_dut (
        .clk (clk),
        .rstb(rstb),
        .bus (bus)
    );

    typedef struct {
        int          phase;
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    rd_vec_t     vecs[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last_word);
        for (int b = 0; b < 4; b++) send_byte(w[b*8 +: 8], last_word && (b == 3));
    endtask

    task automatic pulse_start();
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
    endtask

    task automatic read_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.i_addr = addr;
        exp_q.push_back(exp);
        tick();
        check(name, bus.i_data, exp_q.pop_front());
    endtask

    task automatic run_phase(input int ph);
        foreach (vecs[i])
            if (vecs[i].phase == ph) read_word(vecs[i].name, vecs[i].addr, vecs[i].exp);
    endtask

    initial begin
        vecs.push_back('{1, 32'h0000_0000, 32'h0000_0513, "p1_word0"});
        vecs.push_back('{1, 32'h0000_0004, 32'h0010_0593, "p1_word1"});
        vecs.push_back('{2, 32'h0000_0002, 32'hDDCC_BBAA, "p2_halfword_addr"});
        vecs.push_back('{2, 32'h0000_0004, 32'h0000_00EE, "p2_flush_word"});
        vecs.push_back('{2, 32'h0000_0000, 32'hDDCC_BBAA, "p2_word0"});
        vecs.push_back('{3, 32'h0000_0000, 32'h0302_0100, "b2b_0"});
        vecs.push_back('{3, 32'h0000_0004, 32'h0706_0504, "b2b_4"});
        vecs.push_back('{3, 32'h0000_0008, 32'h0B0A_0908, "b2b_8"});
        vecs.push_back('{3, 32'h0001_0000, 32'h0000_0013, "b2b_out_of_range"});
        vecs.push_back('{3, 32'h0000_000D, 32'h2222_2222, "b2b_low_bits_ignored"});
        vecs.push_back('{4, 32'h0000_0000, 32'hDEAD_BEEF, "ovf_word0_overwritten"});
        vecs.push_back('{4, 32'h0000_0004, 32'h5A5A_5A5A, "ovf_word1"});
        vecs.push_back('{4, 32'h0000_3FFC, 32'h5A5A_5A5A, "ovf_last_word"});
        vecs.push_back('{5, 32'h0000_0000, 32'h1122_3344, "restart_word0"});
        vecs.push_back('{5, 32'h0000_0004, 32'h5A5A_5A5A, "restart_word1_kept"});
        vecs.push_back('{6, 32'h0000_0000, 32'h1122_3344, "after_reset_word0"});

        rstb         = 1'b0;
        bus.i_addr   = 32'h0;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_byte  = 8'h00;
        bus.ld_last  = 1'b0;
        repeat (2) tick();

        check("rst_i_data", bus.i_data, 32'h0000_0013);
        check("rst_busy", 32'(bus.ld_busy), 32'd0);
        check("rst_hold", 32'(bus.core_hold), 32'd0);
        check("rst_ovf", 32'(bus.ld_overflow), 32'd0);
        check("rst_words", 32'(bus.ld_words), 32'd0);
        rstb = 1'b1;
        check("release_i_data", bus.i_data, 32'h0000_0013);
        read_word("post_release_nop", 32'h0001_0000, 32'h0000_0013);

        // Two-word program, complete final word.
        pulse_start();
        check("l1_hold_after_start", 32'(bus.core_hold), 32'd1);
        check("l1_busy_after_start", 32'(bus.ld_busy), 32'd1);
        send_word(32'h0000_0513, 1'b0);
        for (int b = 0; b < 3; b++) send_byte(8'(32'h0010_0593 >> (8 * b)), 1'b0);
        check("l1_hold_before_last", 32'(bus.core_hold), 32'd1);
        send_byte(8'h00, 1'b1);
        check("l1_hold_after_last", 32'(bus.core_hold), 32'd0);
        check("l1_busy_after_last", 32'(bus.ld_busy), 32'd0);
        check("l1_words", 32'(bus.ld_words), 32'd2);
        run_phase(1);

        // Five bytes: final partial word goes through FLUSH.
        pulse_start();
        send_word(32'hDDCC_BBAA, 1'b0);
        send_byte(8'hEE, 1'b1);
        check("l2_hold_in_flush", 32'(bus.core_hold), 32'd1);
        check("l2_words_in_flush", 32'(bus.ld_words), 32'd1);
        tick();
        check("l2_hold_idle", 32'(bus.core_hold), 32'd0);
        check("l2_words", 32'(bus.ld_words), 32'd2);
        run_phase(2);

        // Word 3 rewritten while it is being read: read-first.
        pulse_start();
        send_word(32'h0302_0100, 1'b0);
        send_word(32'h0706_0504, 1'b0);
        send_word(32'h0B0A_0908, 1'b0);
        send_word(32'h1111_1111, 1'b1);
        pulse_start();
        send_word(32'h0302_0100, 1'b0);
        send_word(32'h0706_0504, 1'b0);
        send_word(32'h0B0A_0908, 1'b0);
        for (int b = 0; b < 3; b++) send_byte(8'h22, 1'b0);
        bus.i_addr = 32'h0000_000C;
        exp_q.push_back(32'h1111_1111);
        send_byte(8'h22, 1'b1);
        check("same_cycle_old", bus.i_data, exp_q.pop_front());
        exp_q.push_back(32'h2222_2222);
        tick();
        check("same_cycle_new", bus.i_data, exp_q.pop_front());
        run_phase(3);

        // DEPTH*4 + 4 bytes: address wraps and word 0 is overwritten.
        pulse_start();
        for (int i = 0; i < DEPTH * 4 - 1; i++) send_byte(8'h5A, 1'b0);
        check("ovf_before_wrap", 32'(bus.ld_overflow), 32'd0);
        send_byte(8'h5A, 1'b0);
        check("ovf_at_wrap", 32'(bus.ld_overflow), 32'd1);
        check("ovf_words_full", 32'(bus.ld_words), 32'(DEPTH));
        send_word(32'hDEAD_BEEF, 1'b1);
        check("ovf_sticky", 32'(bus.ld_overflow), 32'd1);
        check("ovf_words_final", 32'(bus.ld_words), 32'(DEPTH + 1));
        check("ovf_hold_done", 32'(bus.core_hold), 32'd0);
        run_phase(4);

        // New load clears counters; a coincident restart drops its byte.
        pulse_start();
        check("restart_ovf_cleared", 32'(bus.ld_overflow), 32'd0);
        check("restart_words_cleared", 32'(bus.ld_words), 32'd0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        bus.ld_start = 1'b1;
        send_byte(8'h99, 1'b0);
        bus.ld_start = 1'b0;
        check("restart_hold", 32'(bus.core_hold), 32'd1);
        send_word(32'h1122_3344, 1'b1);
        check("restart_words", 32'(bus.ld_words), 32'd1);
        run_phase(5);

        // Reset mid-load drops core_hold without a clock edge.
        pulse_start();
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        #2;
        rstb = 1'b0;
        #1;
        check("midload_rst_hold", 32'(bus.core_hold), 32'd0);
        check("midload_rst_busy", 32'(bus.ld_busy), 32'd0);
        check("midload_rst_i_data", bus.i_data, 32'h0000_0013);
        tick();
        rstb = 1'b1;
        send_byte(8'h77, 1'b1);
        check("idle_valid_ignored_busy", 32'(bus.ld_busy), 32'd0);
        check("idle_valid_ignored_words", 32'(bus.ld_words), 32'd0);
        run_phase(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
